// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Purpose  : Instruction-fetch front end. Holds the program counter, issues
//             sequential fetch requests over a request/grant + response-valid
//             memory interface, and buffers returned instructions together
//             with their PCs in a small FIFO that decouples fetch from ID.
//             A redirect flushes the FIFO and marks all in-flight responses
//             for discard, then restarts fetch at the new address.
//  Ports    : CLK, RST          clock, synchronous active-high reset
//             redirect,
//             redirect_pc       flush and restart fetch at redirect_pc
//             imem_req/addr     fetch request and address (out)
//             imem_gnt          request accepted when imem_req && imem_gnt
//             imem_rvalid/rdata in-order instruction response
//             if_valid, if_pc,
//             if_nextPC, if_ins FIFO head toward ID (out)
//             id_ready          ID consumes head when if_valid && id_ready
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_queue #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 4,   // power of two, >= 2
  parameter int               PC_STEP  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc,
  output logic [XLEN-1:0]  if_nextPC,
  output logic [XLEN-1:0]  if_ins,
  input  logic             id_ready
);

  localparam int              c_CNT_W = $clog2(DEPTH + 1);
  localparam int              c_PTR_W = $clog2(DEPTH);
  localparam logic [XLEN-1:0] c_STEP  = XLEN'(PC_STEP);
  localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]    r_fetch_pc;   // next address to request
  logic [XLEN-1:0]    r_resp_pc;    // PC belonging to the next live response
  logic [c_CNT_W-1:0] r_live;       // accepted, not yet returned, not dropped
  logic [c_CNT_W-1:0] r_drop;       // in-flight responses still to discard
  logic [c_CNT_W-1:0] r_occ;        // FIFO occupancy
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;

  logic [XLEN-1:0]    r_fifo_pc  [DEPTH];
  logic [XLEN-1:0]    r_fifo_ins [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [c_CNT_W:0]   w_inflight;
  logic               w_req;
  logic               w_accept;
  logic               w_resp_drop;
  logic               w_resp_live;
  logic               w_push;
  logic               w_pop;
  logic               w_valid;

  // Credit: every live request already owns a FIFO slot, so occupancy plus
  // live requests can never exceed DEPTH and pushes can never overflow.
  assign w_inflight  = {1'b0, r_occ} + {1'b0, r_live};
  assign w_req       = !RST && !redirect && (w_inflight < c_DEPTH);
  assign w_accept    = w_req && imem_gnt;

  // Responses are consumed by the discard counter first; with both counters
  // at zero a stray rvalid matches neither and is ignored.
  assign w_resp_drop = imem_rvalid && (r_drop != '0);
  assign w_resp_live = imem_rvalid && (r_drop == '0) && (r_live != '0);

  assign w_valid     = (r_occ != '0);
  assign w_push      = w_resp_live && !redirect;
  assign w_pop       = w_valid && id_ready && !redirect;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_live     <= '0;
      r_drop     <= '0;
      r_occ      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_resp_pc  <= redirect_pc;
      r_occ      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_live     <= '0;
      // Whatever is still out in memory becomes discard work. A response
      // arriving right now retires one entry of whichever counter it hits.
      r_drop     <= r_drop - c_CNT_W'(w_resp_drop)
                    + r_live - c_CNT_W'(w_resp_live);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + c_STEP;
      end
      r_live <= r_live + c_CNT_W'(w_accept) - c_CNT_W'(w_resp_live);
      r_drop <= r_drop - c_CNT_W'(w_resp_drop);
      if (w_push) begin
        r_wptr    <= r_wptr + c_PTR_W'(1);
        r_resp_pc <= r_resp_pc + c_STEP;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      r_occ <= r_occ + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage (data only; validity is carried by r_occ)
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_fifo_pc[r_wptr]  <= r_resp_pc;
      r_fifo_ins[r_wptr] <= imem_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;

  // Head fields read zero while empty so stale storage never leaks to ID.
  assign if_valid  = w_valid;
  assign if_pc     = w_valid ? r_fifo_pc[r_rptr]            : '0;
  assign if_nextPC = w_valid ? (r_fifo_pc[r_rptr] + c_STEP) : '0;
  assign if_ins    = w_valid ? r_fifo_ins[r_rptr]           : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_queue
//  Purpose  : Self-checking bench for if_fetch_queue. A reference model tracks
//             fetch epochs: each accepted request is tagged with the epoch it
//             was issued in, and a response is delivered only if its epoch is
//             still current when it returns. Delivered PCs are the addresses
//             that were actually requested.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK;
  logic        RST;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_nextPC;
  logic [31:0] if_ins;
  logic        id_ready;

  if_fetch_queue #(
    .XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .PC_STEP(4)
  ) dut (
    .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_nextPC(if_nextPC),
    .if_ins(if_ins), .id_ready(id_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pending[$];   // memory requests in flight, oldest first
  logic [31:0] q[$];         // expected FIFO contents (PCs)
  logic [31:0] m_fetch;
  int          epoch;
  int          cyc;
  int          lat;
  logic        have_resp;
  req_t        cur_resp;
  logic        e_req;
  logic        e_valid;
  logic [31:0] e_pc;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  // Drive the memory response for this cycle and compute expectations.
  task automatic prep();
    int live;
    have_resp = 1'b0;
    if (pending.size() != 0 && pending[0].due == cyc) begin
      have_resp = 1'b1;
      cur_resp  = pending[0];
    end
    imem_rvalid = have_resp;
    imem_rdata  = have_resp ? ins_of(cur_resp.addr) : $urandom;
    #1;
    live = 0;
    foreach (pending[j]) if (pending[j].epoch == epoch) live++;
    e_req   = !RST && !redirect && ((q.size() + live) < DEPTH);
    e_valid = (q.size() != 0);
    e_pc    = e_valid ? q[0] : 32'h0;
  endtask

  // Apply this cycle's inputs to the model, then move to the next cycle.
  task automatic adv();
    logic acc;
    logic rl;
    req_t d;
    acc = e_req && imem_gnt;
    rl  = have_resp && (cur_resp.epoch == epoch);
    if (have_resp) d = pending.pop_front();
    if (RST) begin
      q.delete();
      pending.delete();
      epoch++;
      m_fetch = RESET_PC;
    end else if (redirect) begin
      q.delete();
      epoch++;
      m_fetch = redirect_pc;
    end else begin
      if (q.size() != 0 && id_ready) d.addr = q.pop_front();
      if (rl) q.push_back(cur_resp.addr);
      if (acc) begin
        d.addr  = m_fetch;
        d.epoch = epoch;
        d.due   = cyc + lat;
        pending.push_back(d);
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic do_reset(input int k);
    lat = k;
    RST = 1'b1; redirect = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
    repeat (2) begin prep(); adv(); end
    RST = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    lat = 1;
    RST = 1'b1; redirect = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
    repeat (2) begin prep(); adv(); end
    #1;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: req=%b valid=%b, expected 0 0", imem_req, if_valid);
    end
    checks++;
    if (if_pc !== 32'h0 || if_nextPC !== 32'h0 || if_ins !== 32'h0) begin
      errors++; $display("FAIL reset_head: pc=%h next=%h ins=%h, expected all 0", if_pc, if_nextPC, if_ins);
    end
    checks++;
    if (imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC);
    end
    checks++;
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      prep();
      if (imem_req !== e_req || (e_req && imem_addr !== m_fetch)) begin
        errors++; $display("FAIL rst_req c%0d: req=%b addr=%h expected req=%b addr=%h", i, imem_req, imem_addr, e_req, m_fetch);
      end
      checks++;
      if (if_valid !== e_valid || (e_valid && (if_pc !== e_pc || if_ins !== ins_of(e_pc) || if_nextPC !== e_pc + 32'd4))) begin
        errors++; $display("FAIL rst_head c%0d: valid=%b pc=%h ins=%h next=%h expected valid=%b pc=%h", i, if_valid, if_pc, if_ins, if_nextPC, e_valid, e_pc);
      end
      checks++;
      if (i < 3) begin
        if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
          errors++; $display("FAIL rst_seq c%0d: req=%b addr=%h expected 1 %h", i, imem_req, imem_addr, 32'(i * 4));
        end
        checks++;
      end
      if (i == 2) begin
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_nextPC !== 32'h4) begin
          errors++; $display("FAIL rst_latency: valid=%b pc=%h next=%h expected 1 0 4", if_valid, if_pc, if_nextPC);
        end
        checks++;
      end
      adv();
    end
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset(1);
    id_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      prep();
      if (imem_req !== e_req || (e_req && imem_addr !== m_fetch)) begin
        errors++; $display("FAIL bp_req c%0d: req=%b addr=%h expected req=%b addr=%h", i, imem_req, imem_addr, e_req, m_fetch);
      end
      checks++;
      if (if_valid !== e_valid || (e_valid && (if_pc !== e_pc || if_ins !== ins_of(e_pc)))) begin
        errors++; $display("FAIL bp_head c%0d: valid=%b pc=%h expected valid=%b pc=%h", i, if_valid, if_pc, e_valid, e_pc);
      end
      checks++;
      if (imem_req === 1'b1 && imem_gnt) acc++;
      adv();
    end
    prep();
    if (acc != 4 || imem_req !== 1'b0 || if_pc !== 32'h0) begin
      errors++; $display("FAIL bp_full: accepted=%0d req=%b head=%h expected 4 0 0", acc, imem_req, if_pc);
    end
    checks++;
    id_ready = 1'b1;
    adv();
    prep();
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_pc !== 32'h4) begin
      errors++; $display("FAIL bp_resume: req=%b addr=%h head=%h expected 1 10 4", imem_req, imem_addr, if_pc);
    end
    checks++;
    adv();
  endtask

  task automatic test_grant_stall();
    logic [31:0] exp_seq;
    do_reset(1);
    exp_seq = 32'h0;
    for (int i = 0; i < 14; i++) begin
      imem_gnt = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
      prep();
      if (imem_req !== e_req || (e_req && imem_addr !== m_fetch)) begin
        errors++; $display("FAIL gs_req c%0d: req=%b addr=%h expected req=%b addr=%h", i, imem_req, imem_addr, e_req, m_fetch);
      end
      checks++;
      if (!imem_gnt) begin
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
          errors++; $display("FAIL gs_hold c%0d: req=%b addr=%h expected 1 8", i, imem_req, imem_addr);
        end
        checks++;
      end
      if (if_valid === 1'b1) begin
        if (if_pc !== exp_seq || if_ins !== ins_of(exp_seq)) begin
          errors++; $display("FAIL gs_seq c%0d: pc=%h ins=%h expected pc=%h", i, if_pc, if_ins, exp_seq);
        end
        checks++;
        exp_seq = exp_seq + 32'd4;
      end
      adv();
    end
    imem_gnt = 1'b1;
  endtask

  task automatic test_redirect_inflight();
    logic got;
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin redirect = 1'b1; redirect_pc = 32'h100; end
      prep();
      if (imem_req !== e_req || (e_req && imem_addr !== m_fetch)) begin
        errors++; $display("FAIL ri_req c%0d: req=%b addr=%h expected req=%b addr=%h", i, imem_req, imem_addr, e_req, m_fetch);
      end
      checks++;
      adv();
    end
    redirect = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      prep();
      if (i == 0) begin
        if (if_valid !== 1'b0) begin
          errors++; $display("FAIL ri_flush: valid=%b expected 0", if_valid);
        end
        checks++;
      end
      if (if_valid !== e_valid || (e_valid && (if_pc !== e_pc || if_ins !== ins_of(e_pc)))) begin
        errors++; $display("FAIL ri_head c%0d: valid=%b pc=%h expected valid=%b pc=%h", i, if_valid, if_pc, e_valid, e_pc);
      end
      checks++;
      if (if_valid === 1'b1) begin
        got = 1'b1;
        if (if_pc !== 32'h100) begin
          errors++; $display("FAIL ri_first: pc=%h expected 100", if_pc);
        end
        checks++;
      end
      adv();
    end
    if (!got) begin
      errors++; $display("FAIL ri_timeout: no instruction after redirect, expected pc 100");
    end
    checks++;
  endtask

  task automatic test_redirect_collide();
    logic got;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      redirect    = (i >= 2);
      redirect_pc = (i == 2) ? 32'h200 : 32'h300;
      prep();
      if (i == 2) begin
        if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin
          errors++; $display("FAIL rc_setup: rvalid=%b req=%b expected 1 0", imem_rvalid, imem_req);
        end
        checks++;
      end
      adv();
    end
    redirect = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      prep();
      if (if_valid !== e_valid || (e_valid && (if_pc !== e_pc || if_ins !== ins_of(e_pc)))) begin
        errors++; $display("FAIL rc_head c%0d: valid=%b pc=%h expected valid=%b pc=%h", i, if_valid, if_pc, e_valid, e_pc);
      end
      checks++;
      if (if_valid === 1'b1) begin
        got = 1'b1;
        if (if_pc !== 32'h300) begin
          errors++; $display("FAIL rc_first: pc=%h expected 300", if_pc);
        end
        checks++;
      end
      adv();
    end
    if (!got) begin
      errors++; $display("FAIL rc_timeout: no instruction after redirects, expected pc 300");
    end
    checks++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int n;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    do_reset(1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    prep(); adv();
    redirect = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      prep();
      if (if_valid === 1'b1 && id_ready) begin
        if (if_pc !== exp_pc[n] || if_nextPC !== exp_pc[n] + 32'd4 || if_ins !== ins_of(exp_pc[n])) begin
          errors++; $display("FAIL wrap_%0d: pc=%h next=%h ins=%h expected pc=%h", n, if_pc, if_nextPC, if_ins, exp_pc[n]);
        end
        checks++;
        if (n == 1) begin
          if (if_nextPC !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got %h expected 0", if_nextPC);
          end
          checks++;
        end
        n++;
      end
      adv();
    end
    if (n < 3) begin
      errors++; $display("FAIL wrap_timeout: delivered %0d expected 3", n);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int s = 0; s < 4; s++) begin
      do_reset(int'($urandom_range(1, 3)));
      for (int i = 0; i < 100; i++) begin
        RST         = ($urandom_range(0, 63) == 0);
        redirect    = ($urandom_range(0, 15) == 0);
        redirect_pc = $urandom;
        imem_gnt    = ($urandom_range(0, 3) != 0);
        id_ready    = ($urandom_range(0, 9) < 7);
        prep();
        if (imem_req !== e_req || (e_req && imem_addr !== m_fetch)) begin
          errors++; $display("FAIL rnd_req s%0d c%0d: req=%b addr=%h expected req=%b addr=%h", s, i, imem_req, imem_addr, e_req, m_fetch);
        end
        checks++;
        if (if_valid !== e_valid || (e_valid && (if_pc !== e_pc || if_ins !== ins_of(e_pc) || if_nextPC !== e_pc + 32'd4))) begin
          errors++; $display("FAIL rnd_head s%0d c%0d: valid=%b pc=%h ins=%h expected valid=%b pc=%h", s, i, if_valid, if_pc, if_ins, e_valid, e_pc);
        end
        checks++;
        adv();
      end
    end
    RST = 1'b0; redirect = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
  endtask

  initial begin
    RST = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    epoch = 0; cyc = 0; lat = 1; m_fetch = RESET_PC;
    @(negedge CLK);
    test_reset();
    test_backpressure();
    test_grant_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
